// File: rtl/adder_bist_if.sv
// Bus between the adder BIST initiator and its surroundings: run control,
// operands out to the adder, results back, and the status/report outputs.
interface adder_bist_if #(
  parameter int WIDTH = 4
);
  logic               start;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic               op_cin;
  logic [WIDTH-1:0]   dut_sum;
  logic               dut_cout;
  logic               busy;
  logic               done;
  logic               pass;
  logic [7:0]         err_count;
  logic [8:0]         vec_count;
  logic [7:0]         first_fail_idx;
  logic [2*WIDTH:0]   first_fail_vec;

  // BIST side: drives operands and status, samples start and adder results
  modport master (
    input  start, dut_sum, dut_cout,
    output op_a, op_b, op_cin, busy, done, pass,
           err_count, vec_count, first_fail_idx, first_fail_vec
  );

  // Environment side: pins plus the adder under test
  modport slave (
    output start, dut_sum, dut_cout,
    input  op_a, op_b, op_cin, busy, done, pass,
           err_count, vec_count, first_fail_idx, first_fail_vec
  );
endinterface

// File: rtl/adder_bist.sv
// Built-in self-test initiator for the ripple-carry adder: LFSR-driven
// operands, settle wait, compare against a golden sum, report results.
module adder_bist #(
  parameter int          WIDTH      = 4,
  parameter int          NVEC       = 256,
  parameter int          SETTLE_CYC = 1,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic         clk,
  input  logic         rst,
  adder_bist_if.master bus
);

  localparam int CW = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC + 1);

  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CHECK, DONE} state_e;

  // Field order gives the {cin, b, a} packing used for first_fail_vec
  typedef struct packed {
    logic             cin;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] a;
  } vec_t;

  state_e        state_q, state_d;
  logic [15:0]   lfsr_q, lfsr_d;
  vec_t          op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    err_q, err_d;
  logic [8:0]    vec_q, vec_d;
  logic [7:0]    ffi_q, ffi_d;
  vec_t          ffv_q, ffv_d;

  logic [WIDTH:0] golden;
  logic [8:0]     vec_inc;
  logic [15:0]    lfsr_step;
  logic           busy, done, pass;

  // Next-state, datapath updates and status decode
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    vec_d   = vec_q;
    ffi_d   = ffi_q;
    ffv_d   = ffv_q;

    // Golden sum uses the registered operands, i.e. exactly what the adder sees
    golden    = {1'b0, op_q.a} + {1'b0, op_q.b} + {{WIDTH{1'b0}}, op_q.cin};
    vec_inc   = vec_q + 9'd1;
    // x^16+x^14+x^13+x^11+1, shift left, feedback into bit 0
    lfsr_step = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    busy = (state_q == DRIVE) || (state_q == SETTLE) || (state_q == CHECK);
    done = (state_q == DONE);
    pass = done && (err_q == 8'd0);

    case (state_q)
      IDLE, DONE: begin
        // Restart from DONE reuses the seed, so every run is identical
        if (bus.start) begin
          lfsr_d  = SEED;
          err_d   = 8'd0;
          vec_d   = 9'd0;
          ffi_d   = 8'd0;
          ffv_d   = '0;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        op_d.a   = lfsr_q[WIDTH-1:0];
        op_d.b   = lfsr_q[2*WIDTH-1:WIDTH];
        op_d.cin = lfsr_q[15];
        cnt_d    = CW'(SETTLE_CYC);
        state_d  = SETTLE;
      end
      SETTLE: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) state_d = CHECK;
      end
      CHECK: begin
        if ({bus.dut_cout, bus.dut_sum} != golden) begin
          if (err_q != 8'hFF) err_d = err_q + 8'd1;
          // err_q stays nonzero once set, so zero marks the first failure
          if (err_q == 8'd0) begin
            ffi_d = vec_q[7:0];
            ffv_d = op_q;
          end
        end
        vec_d   = vec_inc;
        lfsr_d  = lfsr_step;
        state_d = (vec_inc == 9'(NVEC)) ? DONE : DRIVE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Datapath and report registers
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= 16'd0;
      op_q   <= '0;
      cnt_q  <= '0;
      err_q  <= 8'd0;
      vec_q  <= 9'd0;
      ffi_q  <= 8'd0;
      ffv_q  <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      op_q   <= op_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
      vec_q  <= vec_d;
      ffi_q  <= ffi_d;
      ffv_q  <= ffv_d;
    end
  end

  assign bus.op_a           = op_q.a;
  assign bus.op_b           = op_q.b;
  assign bus.op_cin         = op_q.cin;
  assign bus.busy           = busy;
  assign bus.done           = done;
  assign bus.pass           = pass;
  assign bus.err_count      = err_q;
  assign bus.vec_count      = vec_q;
  assign bus.first_fail_idx = ffi_q;
  assign bus.first_fail_vec = ffv_q;

endmodule

// File: tb/tb_adder_bist.sv
// Bench for adder_bist: default instance (NVEC=256, SETTLE_CYC=1) with a
// faultable adder model, plus a short instance (NVEC=4, SETTLE_CYC=3).
module tb_adder_bist;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   mode = 0;          // 0 golden, 1 sum bit0 inverted, 2 cout stuck 0
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  adder_bist_if #(.WIDTH(4)) b0 ();
  adder_bist_if #(.WIDTH(4)) b1 ();

  adder_bist #(.WIDTH(4), .NVEC(256), .SETTLE_CYC(1), .SEED(16'hACE1))
    u_dut0 (.clk(clk), .rst(rst), .bus(b0));
  adder_bist #(.WIDTH(4), .NVEC(4), .SETTLE_CYC(3), .SEED(16'hACE1))
    u_dut1 (.clk(clk), .rst(rst), .bus(b1));

  // Adder under test, with optional planted faults
  logic [4:0] s0, s1;
  always_comb begin
    s0 = {1'b0, b0.op_a} + {1'b0, b0.op_b} + {4'd0, b0.op_cin};
    if (mode == 1) s0[0] = ~s0[0];
    if (mode == 2) s0[4] = 1'b0;
    b0.dut_sum  = s0[3:0];
    b0.dut_cout = s0[4];
  end
  always_comb begin
    s1 = {1'b0, b1.op_a} + {1'b0, b1.op_b} + {4'd0, b1.op_cin};
    b1.dut_sum  = s1[3:0];
    b1.dut_cout = s1[4];
  end

  logic [8:0] q0[$];
  logic [8:0] q1[$];

  function automatic logic [15:0] lstep(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Queue the expected vector sequence of one run and predict its report
  task automatic push_run(input int which, input int n, input int fm,
                          output int err, output int ffi, output logic [8:0] ffv);
    logic [15:0] l;
    logic [8:0]  v;
    logic [4:0]  s;
    bit          bad;
    l = 16'hACE1; err = 0; ffi = 0; ffv = '0;
    for (int i = 0; i < n; i++) begin
      v = {l[15], l[7:4], l[3:0]};
      s = {1'b0, v[3:0]} + {1'b0, v[7:4]} + {4'd0, v[8]};
      bad = (fm == 1) || (fm == 2 && s[4]);
      if (bad) begin
        if (err == 0) begin ffi = i; ffv = v; end
        if (err < 255) err++;
      end
      if (which == 0) q0.push_back(v); else q1.push_back(v);
      l = lstep(l);
    end
  endtask

  // Scoreboard monitors: operands are valid from the cycle after DRIVE
  int c0 = 0, c1 = 0;
  logic [8:0] e0, g0, e1, g1;
  always @(posedge clk) begin
    #1;
    if (rst || !b0.busy) c0 = 0;
    else begin
      if (c0 % 3 == 1) begin
        n_cmp++;
        g0 = {b0.op_cin, b0.op_b, b0.op_a};
        if (q0.size() == 0) begin
          n_bad++; $display("FAIL sb0_underflow got %h required none", g0);
        end else begin
          e0 = q0.pop_front();
          if (g0 !== e0) begin
            n_bad++; $display("FAIL sb0_vec got %h required %h", g0, e0);
          end
        end
      end
      c0++;
    end
  end
  always @(posedge clk) begin
    #1;
    if (rst || !b1.busy) c1 = 0;
    else begin
      if (c1 % 5 == 1) begin
        n_cmp++;
        g1 = {b1.op_cin, b1.op_b, b1.op_a};
        if (q1.size() == 0) begin
          n_bad++; $display("FAIL sb1_underflow got %h required none", g1);
        end else begin
          e1 = q1.pop_front();
          if (g1 !== e1) begin
            n_bad++; $display("FAIL sb1_vec got %h required %h", g1, e1);
          end
        end
      end
      c1++;
    end
  end

  // Count edges until done is seen; -1 when the budget runs out
  task automatic wait_done(input int which, input int budget, output int cyc);
    logic d;
    cyc = 0;
    do begin
      @(posedge clk); #1; cyc++;
      d = (which == 0) ? b0.done : b1.done;
    end while (d !== 1'b1 && cyc < budget);
    if (d !== 1'b1) cyc = -1;
  endtask

  task automatic start0();
    @(negedge clk); b0.start = 1'b1;
    @(posedge clk); #1; b0.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; b0.start = 1'b1; b1.start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({b0.busy, b0.done, b0.pass, b0.op_a, b0.op_b, b0.op_cin} !== 12'd0) begin
      n_bad++; $display("FAIL reset_ctl_ops got %h required 0",
                        {b0.busy, b0.done, b0.pass, b0.op_a, b0.op_b, b0.op_cin});
    end
    n_cmp++;
    if ({b0.err_count, b0.vec_count, b0.first_fail_idx, b0.first_fail_vec} !== 34'd0) begin
      n_bad++; $display("FAIL reset_counts got %h required 0",
                        {b0.err_count, b0.vec_count, b0.first_fail_idx, b0.first_fail_vec});
    end
    n_cmp++;
    if ({b1.busy, b1.done} !== 2'b00) begin
      n_bad++; $display("FAIL reset_dut1 got %b required 00", {b1.busy, b1.done});
    end
    @(negedge clk); rst = 1'b0; b0.start = 1'b0; b1.start = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (b0.busy !== 1'b0) begin
      n_bad++; $display("FAIL start_under_reset busy=%b required 0", b0.busy);
    end
  endtask

  task automatic test_golden();
    int err, ffi, cyc; logic [8:0] ffv;
    mode = 0;
    push_run(0, 256, 0, err, ffi, ffv);
    start0();
    n_cmp++;
    if (b0.busy !== 1'b1) begin n_bad++; $display("FAIL golden_busy got %b required 1", b0.busy); end
    @(posedge clk); #1;
    n_cmp++;
    if ({b0.op_cin, b0.op_b, b0.op_a} !== 9'h1E1) begin
      n_bad++; $display("FAIL golden_first_vec got %h required 1e1", {b0.op_cin, b0.op_b, b0.op_a});
    end
    wait_done(0, 2000, cyc);
    n_cmp++;
    if (cyc + 1 != 768) begin n_bad++; $display("FAIL golden_latency got %0d required 768", cyc + 1); end
    n_cmp++;
    if ({b0.pass, b0.busy, b0.err_count, b0.vec_count} !== {1'b1, 1'b0, 8'd0, 9'd256}) begin
      n_bad++; $display("FAIL golden_report pass=%b busy=%b err=%0d vec=%0d required 1 0 0 256",
                        b0.pass, b0.busy, b0.err_count, b0.vec_count);
    end
    n_cmp++;
    if ({b0.first_fail_idx, b0.first_fail_vec} !== 17'd0) begin
      n_bad++; $display("FAIL golden_ff got %h/%h required 0/0", b0.first_fail_idx, b0.first_fail_vec);
    end
  endtask

  task automatic test_sum_fault();
    int err, ffi, cyc; logic [8:0] ffv;
    mode = 1;
    push_run(0, 256, 1, err, ffi, ffv);
    start0();
    wait_done(0, 2000, cyc);
    n_cmp++;
    if (cyc != 768) begin n_bad++; $display("FAIL sumflt_latency got %0d required 768", cyc); end
    n_cmp++;
    if ({b0.err_count, b0.pass} !== {8'd255, 1'b0}) begin
      n_bad++; $display("FAIL sumflt_err err=%0d pass=%b required 255 0", b0.err_count, b0.pass);
    end
    n_cmp++;
    if ({b0.first_fail_idx, b0.first_fail_vec} !== {8'd0, 9'h1E1}) begin
      n_bad++; $display("FAIL sumflt_ff got %h/%h required 00/1e1", b0.first_fail_idx, b0.first_fail_vec);
    end
    n_cmp++;
    if (b0.vec_count !== 9'd256) begin n_bad++; $display("FAIL sumflt_vec got %0d required 256", b0.vec_count); end
  endtask

  task automatic test_cout_fault();
    int err, ffi, cyc; logic [8:0] ffv;
    mode = 2;
    push_run(0, 256, 2, err, ffi, ffv);
    start0();
    wait_done(0, 2000, cyc);
    n_cmp++;
    if (cyc != 768) begin n_bad++; $display("FAIL coutflt_latency got %0d required 768", cyc); end
    n_cmp++;
    if (b0.err_count !== 8'(err) || b0.pass !== (err == 0)) begin
      n_bad++; $display("FAIL coutflt_err err=%0d pass=%b required %0d", b0.err_count, b0.pass, err);
    end
    n_cmp++;
    if (b0.first_fail_idx !== 8'(ffi) || b0.first_fail_vec !== ffv) begin
      n_bad++; $display("FAIL coutflt_ff got %0d/%h required %0d/%h",
                        b0.first_fail_idx, b0.first_fail_vec, ffi, ffv);
    end
    mode = 0;
  endtask

  task automatic test_mid_reset();
    int err, ffi, cyc; logic [8:0] ffv;
    mode = 0;
    push_run(0, 256, 0, err, ffi, ffv);
    start0();
    repeat (99) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    q0.delete();
    n_cmp++;
    if ({b0.busy, b0.done, b0.err_count, b0.vec_count} !== 19'd0) begin
      n_bad++; $display("FAIL midrst_state busy=%b done=%b err=%0d vec=%0d required 0",
                        b0.busy, b0.done, b0.err_count, b0.vec_count);
    end
    n_cmp++;
    if ({b0.op_cin, b0.op_b, b0.op_a} !== 9'd0) begin
      n_bad++; $display("FAIL midrst_ops got %h required 0", {b0.op_cin, b0.op_b, b0.op_a});
    end
    push_run(0, 256, 0, err, ffi, ffv);
    start0();
    @(posedge clk); #1;
    n_cmp++;
    if ({b0.op_cin, b0.op_b, b0.op_a} !== 9'h1E1) begin
      n_bad++; $display("FAIL midrst_first_vec got %h required 1e1", {b0.op_cin, b0.op_b, b0.op_a});
    end
    wait_done(0, 2000, cyc);
    n_cmp++;
    if (cyc + 1 != 768 || b0.pass !== 1'b1) begin
      n_bad++; $display("FAIL midrst_rerun cyc=%0d pass=%b required 768 1", cyc + 1, b0.pass);
    end
  endtask

  task automatic test_back_to_back();
    int err, ffi, cyc; logic [8:0] ffv;
    mode = 0;
    // start pulse while busy must not lengthen or restart the run
    push_run(0, 256, 0, err, ffi, ffv);
    start0();
    repeat (50) @(posedge clk);
    @(negedge clk); b0.start = 1'b1;
    @(posedge clk); #1; b0.start = 1'b0;
    wait_done(0, 2000, cyc);
    n_cmp++;
    if (cyc + 51 != 768) begin n_bad++; $display("FAIL busy_start_latency got %0d required 768", cyc + 51); end
    // start pulse in DONE replays the identical sequence
    push_run(0, 256, 0, err, ffi, ffv);
    start0();
    n_cmp++;
    if ({b0.done, b0.busy, b0.vec_count} !== {1'b0, 1'b1, 9'd0}) begin
      n_bad++; $display("FAIL done_restart done=%b busy=%b vec=%0d required 0 1 0",
                        b0.done, b0.busy, b0.vec_count);
    end
    wait_done(0, 2000, cyc);
    n_cmp++;
    if (cyc != 768 || b0.pass !== 1'b1 || b0.vec_count !== 9'd256) begin
      n_bad++; $display("FAIL replay cyc=%0d pass=%b vec=%0d required 768 1 256",
                        cyc, b0.pass, b0.vec_count);
    end
    // start held high: one run, immediate restart with counters re-cleared
    mode = 1;
    push_run(0, 256, 1, err, ffi, ffv);
    push_run(0, 256, 1, err, ffi, ffv);
    @(negedge clk); b0.start = 1'b1;
    @(posedge clk); #1;
    wait_done(0, 2000, cyc);
    n_cmp++;
    if (cyc != 768 || b0.err_count !== 8'd255) begin
      n_bad++; $display("FAIL held_first cyc=%0d err=%0d required 768 255", cyc, b0.err_count);
    end
    @(posedge clk); #1; b0.start = 1'b0;
    n_cmp++;
    if ({b0.done, b0.busy, b0.err_count, b0.vec_count} !== {1'b0, 1'b1, 8'd0, 9'd0}) begin
      n_bad++; $display("FAIL held_restart done=%b busy=%b err=%0d vec=%0d required 0 1 0 0",
                        b0.done, b0.busy, b0.err_count, b0.vec_count);
    end
    wait_done(0, 2000, cyc);
    n_cmp++;
    if (cyc != 768 || b0.err_count !== 8'd255) begin
      n_bad++; $display("FAIL held_second cyc=%0d err=%0d required 768 255", cyc, b0.err_count);
    end
    mode = 0;
  endtask

  task automatic test_short_cfg();
    int err, ffi, cyc; logic [8:0] ffv;
    push_run(1, 4, 0, err, ffi, ffv);
    @(negedge clk); b1.start = 1'b1;
    @(posedge clk); #1; b1.start = 1'b0;
    wait_done(1, 200, cyc);
    n_cmp++;
    if (cyc != 20) begin n_bad++; $display("FAIL short_latency got %0d required 20", cyc); end
    n_cmp++;
    if ({b1.pass, b1.vec_count, b1.err_count} !== {1'b1, 9'd4, 8'd0}) begin
      n_bad++; $display("FAIL short_report pass=%b vec=%0d err=%0d required 1 4 0",
                        b1.pass, b1.vec_count, b1.err_count);
    end
  endtask

  initial begin
    b0.start = 1'b0; b1.start = 1'b0;
    test_reset();
    test_golden();
    test_sum_fault();
    test_cout_fault();
    test_mid_reset();
    test_back_to_back();
    test_short_cfg();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_bad++; $display("FAIL sb_leftover got %0d/%0d required 0/0", q0.size(), q1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
